dense_buf_reader: RTL and testbench
===================================

Name: dense_buf_reader

Overview:
- Read-side sequencer for the 128-bit dense buffer (DEPTH rows, 6-bit address).
- On a start command it issues a run of combinational reads from a base address, capturing each row into a 2-entry output FIFO.
- It streams the rows to the 16x16 int8 compute core over a valid/ready interface, marking the final beat with last.
- It is the consumer at the read channel of the dense buffer, which has a combinational read port.

Parameters:
- DATA_WIDTH, 128, row width in bits; must match the buffer.
- ADDR_WIDTH, 6, buffer address width.
- DEPTH, 60, number of buffer rows; addresses wrap at DEPTH-1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- start_i  input  1  one-cycle command pulse
- base_addr_i  input  ADDR_WIDTH  first row to read; sampled with start_i; must be < DEPTH
- len_i  input  ADDR_WIDTH+1  number of rows (0..DEPTH); sampled with start_i
- abort_i  input  1  cancel the current run
- rd_en_o  output  1  buffer read enable
- rd_addr_o  output  ADDR_WIDTH  buffer read address
- rd_data_i  input  DATA_WIDTH  buffer read data; valid in the same cycle as rd_en_o
- m_valid_o  output  1  stream valid
- m_ready_i  input  1  stream ready
- m_data_o  output  DATA_WIDTH  stream row
- m_last_o  output  1  final row of the run
- busy_o  output  1  high from accepted start until done
- done_o  output  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - All outputs go to 0.
  - FIFO is emptied, FSM returns to IDLE, counters are cleared.
  - Reset in the middle of a run discards all pending rows, and no done_o is produced.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start_i=1 with len_i>0 latches base/len, sets busy_o, and moves to ISSUE. start_i=1 with len_i=0 moves to DONE with no reads. start_i is ignored in every state except IDLE.
  - ISSUE, per cycle:
    - rd_en_o=1 iff the FIFO will have space: occupancy<2, or occupancy==2 while a pop occurs this cycle.
    - When rd_en_o=1, rd_data_i is pushed into the FIFO at the clock edge, tagged last when the remaining count is 1.
    - rd_addr_o increments after each issued read; DEPTH-1 wraps to 0.
    - Move to DRAIN after the len-th read is issued.
  - DRAIN: wait until the FIFO is empty and the last beat has been accepted (m_valid_o & m_ready_i & m_last_o), then move to DONE.
  - DONE: done_o=1 for exactly one cycle, busy_o falls in the same cycle, then IDLE.
- rd_en_o is 0 in IDLE, DRAIN and DONE. rd_addr_o holds its last value when not reading.
- FIFO and stream:
  - m_valid_o = FIFO not empty.
  - m_data_o and m_last_o come from the head entry and are registered; they are not combinational from rd_data_i.
  - Push and pop in the same cycle keep occupancy unchanged.
  - Data and last must stay stable while m_valid_o=1 and m_ready_i=0.
- Latency and throughput:
  - start_i at edge N gives rd_en_o=1 at cycle N+1 and m_valid_o=1 at cycle N+2.
  - With m_ready_i held high, one row per cycle; a len=L run completes with done_o at cycle N+L+2.
- Backpressure: with m_ready_i=0, at most 2 rows are read ahead, then rd_en_o=0 until a pop.
- Abort: abort_i=1 in any non-IDLE state flushes the FIFO, drops m_valid_o next cycle, goes to DONE, and pulses done_o. abort_i in IDLE has no effect.
- Simultaneous events:
  - rst dominates abort_i, which dominates start_i.
  - start_i is only sampled in IDLE, so start_i in the DONE cycle is ignored.
- Width rule: the remaining counter is ADDR_WIDTH+1 bits; len_i>DEPTH is illegal and saturates to DEPTH.

Optional Feature:
- DENSE_RD_PERF_EN defined:
  - Adds output stall_cnt_o [15:0], counting cycles with m_valid_o=1 and m_ready_i=0 during a run.
  - Cleared on an accepted start; saturates at 16'hFFFF; holds after done.
  - Reset value 0.
- DENSE_RD_PERF_EN undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- base=0, len=4, rows preloaded 0x..00..0x..03, ready=1 -> rd_addr_o 0,1,2,3 on consecutive cycles; 4 beats in order; m_last_o on beat 4; done_o at start+6.
- base=58, len=4 -> addresses 58,59,0,1 (wrap); data order matches.
- len=3, ready=0 for 5 cycles then 1 -> exactly 2 reads issued before stall; m_data_o stable; all 3 beats delivered with no loss or duplication.
- len=0 -> no rd_en_o; done_o pulses 1 cycle after start; m_valid_o stays 0.
- len=10, abort_i after 3 beats accepted -> m_valid_o low next cycle; done_o pulses; next start with base=5, len=2 works cleanly.
- rst asserted mid-run (len=8, after 2 beats) -> all outputs 0 next cycle; no done_o; busy_o=0; DENSE_RD_PERF_EN build: stall_cnt_o=0.

Source files
------------

// File: rtl/dense_buf_reader.sv
// Read-side sequencer: streams a run of dense-buffer rows to the compute core, tagging the final beat with last.
// Latency: start at edge N -> rd_en_o in cycle N+1, m_valid_o in N+2, done_o in N+L+2 with ready held high.
// Backpressure: a 2-entry output FIFO; reads stall when it is full and not popping. Option macro DENSE_RD_PERF_EN adds stall_cnt_o.
module dense_buf_reader #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic                  abort_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  busy_o,
`ifdef DENSE_RD_PERF_EN
    output logic [15:0]           stall_cnt_o,
`endif
    output logic                  done_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = ADDR_WIDTH'(DEPTH - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   len_sat;
    logic [DATA_WIDTH-1:0] fifo_dat [2];
    logic [1:0]            fifo_last;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;
    logic                  push, pop, flush;
    logic                  accept_start;

    // Oversized lengths are clamped to a full buffer sweep.
    assign len_sat      = (len_i > CNT_DEPTH) ? CNT_DEPTH : len_i;
    assign accept_start = (state == IDLE) && start_i;
    assign m_valid_o    = (count != 2'd0);
    assign pop          = m_valid_o && m_ready_i;
    assign push         = rd_en_o;
    assign m_data_o     = fifo_dat[rd_ptr];
    assign m_last_o     = fifo_last[rd_ptr];

    // Next-state and Moore/Mealy outputs; abort wins over normal progress.
    always_comb begin
        state_nxt = state;
        rd_en_o   = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        flush     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = (len_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                busy_o  = 1'b1;
                rd_en_o = (count != 2'd2) || pop;
                if (abort_i) begin
                    flush     = 1'b1;
                    state_nxt = DONE;
                end else if (rd_en_o && (remaining == CNT_ONE)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    flush     = 1'b1;
                    state_nxt = DONE;
                end else if ((count == 2'd0) || ((count == 2'd1) && pop && m_last_o)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Run bookkeeping: load base/length on start, advance address with wrap on every issued read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_o <= '0;
            remaining <= '0;
        end else if (accept_start) begin
            rd_addr_o <= base_addr_i;
            remaining <= len_sat;
        end else if (rd_en_o) begin
            remaining <= remaining - CNT_ONE;
            rd_addr_o <= (rd_addr_o == ADDR_MAX) ? '0 : rd_addr_o + ADDR_WIDTH'(1);
        end
    end

    // FIFO pointers and occupancy; abort flushes everything in flight.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; a slot is only written when it is free or being popped, so the head stays stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_dat[i] <= '0;
            end
            fifo_last <= '0;
        end else if (push && !flush) begin
            fifo_dat[wr_ptr]  <= rd_data_i;
            fifo_last[wr_ptr] <= (remaining == CNT_ONE);
        end
    end

`ifdef DENSE_RD_PERF_EN
    // Count stalled beats during a run; cleared on start, saturating, held afterwards.
    always_ff @(posedge clk) begin
        if (rst || accept_start) begin
            stall_cnt_o <= '0;
        end else if (busy_o && m_valid_o && !m_ready_i && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dense_buf_reader.sv
// Directed bench for dense_buf_reader: per-cycle vector table plus a hand-written mid-run reset sequence.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
// A preloaded row array models the combinational-read dense buffer.
module tb_dense_buf_reader;

    localparam int DW    = 128;
    localparam int AW    = 6;
    localparam int DEPTH = 60;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic [AW-1:0]  base_addr_i;
    logic [AW:0]    len_i;
    logic           abort_i;
    logic           rd_en_o;
    logic [AW-1:0]  rd_addr_o;
    logic [DW-1:0]  rd_data_i;
    logic           m_valid_o;
    logic           m_ready_i;
    logic [DW-1:0]  m_data_o;
    logic           m_last_o;
    logic           busy_o;
    logic           done_o;
`ifdef DENSE_RD_PERF_EN
    logic [15:0]    stall_cnt_o;
`endif

    logic [DW-1:0]  mem [DEPTH];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          start;
        logic [AW-1:0] base;
        logic [AW:0]   len;
        logic          abort;
        logic          ready;
        logic          e_rd;
        logic [AW-1:0] e_addr;
        logic          e_vld;
        logic [AW-1:0] e_row;
        logic          e_last;
        logic          e_busy;
        logic          e_done;
        logic          cs;
        logic [15:0]   e_stall;
    } vec_t;

    vec_t vecs[$];

    dense_buf_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .abort_i     (abort_i),
        .rd_en_o     (rd_en_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_i   (rd_data_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_last_o    (m_last_o),
        .busy_o      (busy_o),
`ifdef DENSE_RD_PERF_EN
        .stall_cnt_o (stall_cnt_o),
`endif
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    assign rd_data_i = mem[rd_addr_o];

    function automatic logic [DW-1:0] row(input int a);
        logic [AW-1:0] a6;
        a6 = a[AW-1:0];
        return {4{24'hC0FFEE, 2'b00, a6}};
    endfunction

    function automatic vec_t mk(input int st, input int b, input int l, input int ab, input int rdy,
                                input int rd, input int ea, input int vld, input int er, input int el,
                                input int eb, input int ed, input int cs, input int es);
        vec_t v;
        v.start   = st[0];
        v.base    = b[AW-1:0];
        v.len     = l[AW:0];
        v.abort   = ab[0];
        v.ready   = rdy[0];
        v.e_rd    = rd[0];
        v.e_addr  = ea[AW-1:0];
        v.e_vld   = vld[0];
        v.e_row   = er[AW-1:0];
        v.e_last  = el[0];
        v.e_busy  = eb[0];
        v.e_done  = ed[0];
        v.cs      = cs[0];
        v.e_stall = es[15:0];
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic set_in(input int st, input int b, input int l, input int ab, input int rdy);
        start_i     = st[0];
        base_addr_i = b[AW-1:0];
        len_i       = l[AW:0];
        abort_i     = ab[0];
        m_ready_i   = rdy[0];
    endtask

    task automatic chk_zero(input int idx);
        chk("zero_rd_en", idx, DW'(rd_en_o),   '0);
        chk("zero_addr",  idx, DW'(rd_addr_o), '0);
        chk("zero_valid", idx, DW'(m_valid_o), '0);
        chk("zero_data",  idx, m_data_o,       '0);
        chk("zero_last",  idx, DW'(m_last_o),  '0);
        chk("zero_busy",  idx, DW'(busy_o),    '0);
        chk("zero_done",  idx, DW'(done_o),    '0);
`ifdef DENSE_RD_PERF_EN
        chk("zero_stall", idx, DW'(stall_cnt_o), '0);
`endif
    endtask

    initial begin
        int done_seen;
        for (int i = 0; i < DEPTH; i++) mem[i] = row(i);

        //          st base len ab rdy | rd addr vld row last busy done | cs stall
        // base 0, len 4, ready high
        vecs.push_back(mk(1, 0, 4, 0, 1,   0, 0, 0, 0, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 1, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 1, 1, 0, 0, 1, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 2, 1, 1, 0, 1, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 3, 1, 2, 0, 1, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 3, 1, 1, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1,   1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0,   0, 0));
        // base 58, len 4: address wrap
        vecs.push_back(mk(1, 58, 4, 0, 1,  0, 0, 0, 0, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 58, 0, 0, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 59, 1, 58, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 0, 1, 59, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 1, 1, 0, 0, 1, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 1, 1, 1, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1,   0, 0));
        // len 0: done next cycle; start during DONE is ignored
        vecs.push_back(mk(1, 7, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0,   0, 0));
        vecs.push_back(mk(1, 3, 2, 0, 1,   0, 0, 0, 0, 0, 0, 1,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0,   0, 0));
        // base 10, len 3, ready low for 5 cycles
        vecs.push_back(mk(1, 10, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 10, 0, 0, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 11, 1, 10, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 1, 10, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 1, 10, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 12, 1, 10, 0, 1, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 11, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 12, 1, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1,   1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0,   1, 3));
        // base 20, len 10, abort after 3 beats; then base 5, len 2
        vecs.push_back(mk(1, 20, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 20, 0, 0, 0, 1, 0,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 21, 1, 20, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 22, 1, 21, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 23, 1, 22, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1,   1, 24, 1, 23, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1,   0, 0));
        vecs.push_back(mk(1, 5, 2, 0, 1,   0, 0, 0, 0, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 5, 0, 0, 0, 1, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 6, 1, 5, 0, 1, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 6, 1, 1, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0,   0, 0));

        // Reset state
        rst = 1'b1;
        set_in(0, 0, 0, 0, 1);
        repeat (2) @(negedge clk);
        #1;
        chk_zero(-1);
        rst = 1'b0;

        // Table-driven cycles
        foreach (vecs[i]) begin
            @(negedge clk);
            set_in(int'(vecs[i].start), int'(vecs[i].base), int'(vecs[i].len),
                   int'(vecs[i].abort), int'(vecs[i].ready));
            #1;
            chk("rd_en", i, DW'(rd_en_o),   DW'(vecs[i].e_rd));
            chk("valid", i, DW'(m_valid_o), DW'(vecs[i].e_vld));
            chk("busy",  i, DW'(busy_o),    DW'(vecs[i].e_busy));
            chk("done",  i, DW'(done_o),    DW'(vecs[i].e_done));
            if (vecs[i].e_rd) chk("rd_addr", i, DW'(rd_addr_o), DW'(vecs[i].e_addr));
            if (vecs[i].e_vld) begin
                chk("data", i, m_data_o, row(int'(vecs[i].e_row)));
                chk("last", i, DW'(m_last_o), DW'(vecs[i].e_last));
            end
`ifdef DENSE_RD_PERF_EN
            if (vecs[i].cs) chk("stall_cnt", i, DW'(stall_cnt_o), DW'(vecs[i].e_stall));
`endif
        end

        // Reset in the middle of a run: base 30, len 8, two stalled cycles, two beats accepted
        @(negedge clk); set_in(1, 30, 8, 0, 0);
        repeat (3) begin @(negedge clk); set_in(0, 0, 0, 0, 0); end
        repeat (2) begin @(negedge clk); set_in(0, 0, 0, 0, 1); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("pre_rst_data", 100, m_data_o, row(32));
        chk("pre_rst_busy", 100, DW'(busy_o), DW'(1'b1));
`ifdef DENSE_RD_PERF_EN
        chk("pre_rst_stall", 100, DW'(stall_cnt_o), DW'(16'd2));
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero(101);
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            if (done_o || busy_o || m_valid_o || rd_en_o) done_seen++;
        end
        chk("post_rst_quiet", 102, DW'(done_seen), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
